cnn_layer_seq: RTL and testbench

- Top-level sequencer for the CNN inference chain: conv0, max0, conv1, max1, dense, out.
- On a frame start request, it launches each layer in order with a one-cycle start pulse and waits for that layer's completion pulse before launching the next.
- Signals frame completion and counts completed frames.
- A watchdog flags a hung layer and parks the sequencer in an error state until software clears it.

---
 rtl/cnn_layer_seq_if.sv | 12 +
 rtl/cnn_layer_seq.sv | 147 ++++++++++++++
 tb/tb_cnn_layer_seq.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_layer_seq_if.sv
// rtl/cnn_layer_seq_if.sv - layer start/done handshake bundle between the frame sequencer and its CNN layers
interface cnn_layer_seq_if #(
  parameter int NUM_LAYERS = 6,
  parameter int SEL_W      = 3
);
  logic [NUM_LAYERS-1:0] lyr_strt;
  logic [NUM_LAYERS-1:0] lyr_done;
  logic [SEL_W-1:0]      lyr_sel;

  modport master (output lyr_strt, output lyr_sel, input lyr_done);
  modport slave  (input lyr_strt, input lyr_sel, output lyr_done);
endinterface

// File: rtl/cnn_layer_seq.sv
// rtl/cnn_layer_seq.sv - frame sequencer launching CNN layers in order, with per-layer watchdog
// Optional per-layer cycle counters are built when CNN_LYR_PERF_EN is defined.
module cnn_layer_seq #(
  parameter int NUM_LAYERS = 6,
  parameter int SEL_W      = 3,
  parameter int TMO_W      = 20,
  parameter int TMO_LIMIT  = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_strt,
  input  logic             i_clr_err,
  input  logic [SEL_W-1:0] i_perf_sel,
  cnn_layer_seq_if.master  io_lyr,
  output logic             o_bsy,
  output logic             o_done,
  output logic             o_err,
  output logic [15:0]      o_frm_cnt,
  output logic [31:0]      o_perf_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_LAYERS - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TMO_LIMIT - 1);

  state_t                r_state;
  state_t                w_nxt_state;
  logic [SEL_W-1:0]      r_idx;
  logic [SEL_W-1:0]      w_nxt_idx;
  logic [NUM_LAYERS-1:0] r_lyr_strt;
  logic [NUM_LAYERS-1:0] w_launch_vec;
  logic                  r_bsy;
  logic                  r_done;
  logic                  r_err;
  logic [15:0]           r_frm_cnt;
  logic [TMO_W-1:0]      r_wdog;
  logic                  w_lyr_hit;
  logic                  w_tmo;

  assign w_lyr_hit = io_lyr.lyr_done[r_idx];
  assign w_tmo     = (r_wdog == TMO_MAX);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (i_strt) begin
          w_nxt_idx   = '0;
          w_nxt_state = S_LAUNCH;
        end
      end
      S_LAUNCH: w_nxt_state = S_WAIT;
      S_WAIT: begin
        // a completion arriving on the last watchdog cycle still counts
        if (w_lyr_hit) begin
          if (r_idx == LAST_IDX) begin
            w_nxt_state = S_DONE;
          end else begin
            w_nxt_idx   = r_idx + SEL_W'(1);
            w_nxt_state = S_LAUNCH;
          end
        end else if (w_tmo) begin
          w_nxt_state = S_ERR;
        end
      end
      S_DONE: w_nxt_state = S_IDLE;
      S_ERR: begin
        if (i_clr_err) w_nxt_state = S_IDLE;
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_launch_vec = '0;
    if (w_nxt_state == S_LAUNCH) w_launch_vec[w_nxt_idx] = 1'b1;
  end

  // outputs are decoded from the next state so they are registered yet line up with the state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_lyr_strt <= '0;
      r_bsy      <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_frm_cnt  <= '0;
      r_wdog     <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_idx      <= w_nxt_idx;
      r_lyr_strt <= w_launch_vec;
      r_bsy      <= (w_nxt_state == S_LAUNCH) || (w_nxt_state == S_WAIT) ||
                    (w_nxt_state == S_DONE);
      r_done     <= (w_nxt_state == S_DONE);
      r_err      <= (w_nxt_state == S_ERR);
      if (r_state == S_DONE) r_frm_cnt <= r_frm_cnt + 16'd1;
      if (r_state == S_LAUNCH) begin
        r_wdog <= '0;
      end else if ((r_state == S_WAIT) && !w_lyr_hit && !w_tmo) begin
        r_wdog <= r_wdog + TMO_W'(1);
      end
    end
  end

  assign io_lyr.lyr_strt = r_lyr_strt;
  assign io_lyr.lyr_sel  = r_idx;
  assign o_bsy           = r_bsy;
  assign o_done          = r_done;
  assign o_err           = r_err;
  assign o_frm_cnt       = r_frm_cnt;

`ifdef CNN_LYR_PERF_EN
  logic [31:0] r_perf [NUM_LAYERS];
  logic [31:0] r_perf_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LAYERS; i++) r_perf[i] <= '0;
      r_perf_cnt <= '0;
    end else begin
      if (r_state == S_LAUNCH) begin
        r_perf[r_idx] <= '0;
      end else if ((r_state == S_WAIT) && (r_perf[r_idx] != 32'hFFFF_FFFF)) begin
        r_perf[r_idx] <= r_perf[r_idx] + 32'd1;
      end
      r_perf_cnt <= (int'(i_perf_sel) < NUM_LAYERS) ? r_perf[i_perf_sel] : '0;
    end
  end

  assign o_perf_cnt = r_perf_cnt;
`else
  logic w_unused_perf_sel;
  assign w_unused_perf_sel = ^i_perf_sel;
  assign o_perf_cnt        = '0;
`endif

endmodule

// File: tb/tb_cnn_layer_seq.sv
// tb/tb_cnn_layer_seq.sv - randomized self-checking bench for cnn_layer_seq against a frame schedule model
module tb_cnn_layer_seq;
  localparam int NL  = 6;
  localparam int SW  = 3;
  localparam int TMO = 16;
`ifdef CNN_LYR_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          strt;
  logic          clr_err;
  logic [SW-1:0] perf_sel;
  logic          bsy;
  logic          done;
  logic          err;
  logic [15:0]   frm_cnt;
  logic [31:0]   perf_cnt;

  int n_run  = 0;
  int n_fail = 0;
  int frm_model;
  int sel_prev;
  int perf_model [NL];
  int lat [NL];

  always #5 clk = ~clk;

  cnn_layer_seq_if #(.NUM_LAYERS(NL), .SEL_W(SW)) lbus ();

  cnn_layer_seq #(
    .NUM_LAYERS(NL),
    .SEL_W     (SW),
    .TMO_W     (20),
    .TMO_LIMIT (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_strt    (strt),
    .i_clr_err (clr_err),
    .i_perf_sel(perf_sel),
    .io_lyr    (lbus),
    .o_bsy     (bsy),
    .o_done    (done),
    .o_err     (err),
    .o_frm_cnt (frm_cnt),
    .o_perf_cnt(perf_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] perf_exp(input int k);
    if (!PERF_EN || k >= NL) return 32'd0;
    return 32'(perf_model[k]);
  endfunction

  task automatic perf_sweep();
    strt    = 1'b0;
    clr_err = 1'b0;
    for (int k = 0; k < 8; k++) begin
      perf_sel = SW'(k);
      @(posedge clk); #1;
      check("perf_cnt", perf_cnt, perf_exp(k));
    end
  endtask

  // lat[i] = cycles from lyr_strt[i] to lyr_done[i]; 0 means the layer never answers
  task automatic run_frame(input int lt[NL], input int rst_lyr, input int noise, input bit hold);
    int lc [NL];
    int n_launch, err_c, done_c, rst_c, end_c, cj, exp_sel, exp_frm;
    logic [NL-1:0] dn, exp_strt;
    bit exp_bsy;
    lc[0] = 1; n_launch = 0; err_c = -1; done_c = -1; rst_c = -1;
    for (int i = 0; i < NL; i++) begin
      n_launch = i + 1;
      if (i == rst_lyr) begin rst_c = lc[i] + 2; break; end
      if (lt[i] == 0) begin err_c = lc[i] + TMO + 1; break; end
      if (i < NL - 1) lc[i+1] = lc[i] + lt[i] + 1;
      else done_c = lc[i] + lt[i] + 1;
    end
    end_c = (done_c >= 0) ? done_c : (err_c >= 0) ? err_c : rst_c + 1;

    for (int t = 0; t <= end_c; t++) begin
      cj = -1;
      for (int j = 0; j < n_launch; j++) if (lc[j] <= t) cj = j;
      rst = (t == rst_c);
      if (t == 0 || hold) strt = 1'b1;
      else if (rst_c >= 0 && t >= rst_c) strt = 1'b0;
      else strt = 1'($urandom);
      clr_err  = (err_c >= 0 && t >= err_c) ? 1'b0 : 1'($urandom);
      perf_sel = SW'($urandom);
      dn = (noise == 2) ? '1 : (noise == 1) ? NL'($urandom) : '0;
      if (cj >= 0 && t > lc[cj]) dn[cj] = 1'b0;
      if (cj >= 0 && cj != rst_lyr && lt[cj] != 0 && t == lc[cj] + lt[cj]) dn[cj] = 1'b1;
      lbus.lyr_done = dn;
      @(negedge clk);
      exp_strt = '0;
      for (int j = 0; j < n_launch; j++) if (lc[j] == t) exp_strt[j] = 1'b1;
      exp_bsy = (t >= 1) && ((done_c >= 0 && t <= done_c) || (err_c >= 0 && t < err_c) ||
                             (rst_c >= 0 && t <= rst_c));
      exp_sel = (rst_c >= 0 && t > rst_c) ? 0 : (t == 0) ? sel_prev : cj;
      exp_frm = (rst_c >= 0 && t > rst_c) ? 0 : frm_model;
      check("lyr_strt", 32'(lbus.lyr_strt), 32'(exp_strt));
      check("bsy", 32'(bsy), 32'(exp_bsy));
      check("done", 32'(done), 32'(t == done_c));
      check("err", 32'(err), 32'(err_c >= 0 && t >= err_c));
      check("lyr_sel", 32'(lbus.lyr_sel), 32'(exp_sel));
      check("frm_cnt", 32'(frm_cnt), 32'(exp_frm));
      @(posedge clk); #1;
    end

    lbus.lyr_done = '0;
    strt = 1'b0; clr_err = 1'b0; rst = 1'b0;
    for (int j = 0; j < n_launch; j++) if (j != rst_lyr) perf_model[j] = (lt[j] != 0) ? lt[j] : TMO;
    if (done_c >= 0) begin
      frm_model = (frm_model + 1) & 16'hFFFF;
      sel_prev  = NL - 1;
    end else if (err_c >= 0) begin
      sel_prev = n_launch - 1;
      for (int k = 0; k < 3; k++) begin
        strt = 1'b1;
        @(posedge clk); #1;
        check("err_sticky", 32'(err), 32'd1);
        check("err_bsy", 32'(bsy), 32'd0);
        check("err_nolaunch", 32'(lbus.lyr_strt), 32'd0);
        check("err_sel", 32'(lbus.lyr_sel), 32'(sel_prev));
      end
    end else begin
      frm_model = 0;
      sel_prev  = 0;
      for (int j = 0; j < NL; j++) perf_model[j] = 0;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        check("rst_nolaunch", 32'(lbus.lyr_strt), 32'd0);
        check("rst_bsy", 32'(bsy), 32'd0);
      end
    end
    if (!hold) perf_sweep();
    if (err_c >= 0) begin
      clr_err = 1'b1; strt = 1'b1;
      @(posedge clk); #1;
      check("clr_err", 32'(err), 32'd0);
      check("clr_nolaunch", 32'(lbus.lyr_strt), 32'd0);
      check("clr_bsy", 32'(bsy), 32'd0);
      clr_err = 1'b0; strt = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; strt = 1'b0; clr_err = 1'b0; perf_sel = '0;
    lbus.lyr_done = '0;
    frm_model = 0; sel_prev = 0;
    for (int j = 0; j < NL; j++) perf_model[j] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_lyr_strt", 32'(lbus.lyr_strt), 32'd0);
    check("rst_lyr_sel", 32'(lbus.lyr_sel), 32'd0);
    check("rst_bsy", 32'(bsy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_frm_cnt", 32'(frm_cnt), 32'd0);
    check("rst_perf", perf_cnt, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NL; i++) lat[i] = 3;
    run_frame(lat, -1, 0, 1'b0);
    run_frame(lat, -1, 2, 1'b0);

    lat = '{3, 4, 0, 3, 3, 3};
    run_frame(lat, -1, 1, 1'b0);

    lat = '{2, 5, 1, 16, 3, 1};
    run_frame(lat, -1, 1, 1'b0);

    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < NL; i++) lat[i] = $urandom_range(1, TMO);
      if ($urandom_range(0, 3) == 0) lat[$urandom_range(0, NL - 1)] = 0;
      run_frame(lat, -1, 1, 1'b0);
    end

    for (int i = 0; i < NL; i++) lat[i] = $urandom_range(1, TMO);
    run_frame(lat, 4, 1, 1'b0);

    force dut.r_frm_cnt = 16'hFFFF;
    @(posedge clk); #1;
    release dut.r_frm_cnt;
    frm_model = 16'hFFFF;
    for (int i = 0; i < NL; i++) lat[i] = $urandom_range(1, 6);
    run_frame(lat, -1, 1, 1'b0);

    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < NL; i++) lat[i] = $urandom_range(1, TMO);
      run_frame(lat, -1, 1, 1'b1);
    end

    strt = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("idle_nolaunch", 32'(lbus.lyr_strt), 32'd0);
      check("final_frm_cnt", 32'(frm_cnt), 32'(frm_model));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL tb_timeout: simulation did not finish, checks run %0d", n_run);
    $fatal(1);
  end

endmodule
